// File: rtl/psum_acc_pkg.sv
// Shared constants and the lane saturation helper for the partial-sum accumulator.
package psum_acc_pkg;

   localparam int INFO_GRP_BIT  = 12;
   localparam int INFO_HALF_BIT = 13;
   localparam int INFO_OFF_W    = 12;
   localparam int BUF_AW        = 13;

   typedef enum logic [1:0] {
      SAT_NONE,
      SAT_MAX,
      SAT_MIN
   } sat_e;

   // Classify a one-bit-wider signed sum: overflow when the top two bits differ.
   function automatic sat_e sat_kind(input logic sum_msb, input logic res_msb);
      if (sum_msb == res_msb) return SAT_NONE;
      return sum_msb ? SAT_MIN : SAT_MAX;
   endfunction

endpackage

// File: rtl/psum_sat_add.sv
// One lane: signed add at PSUM_W+1 bits, clamped back to signed PSUM_W.
module psum_sat_add
   import psum_acc_pkg::*;
#(
   parameter int PSUM_W = 24
) (
   input  logic [PSUM_W-1:0] a,
   input  logic [PSUM_W-1:0] b,
   output logic [PSUM_W-1:0] y
);

   logic [PSUM_W:0] sum;

   assign sum = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};

   always_comb begin
      y = sum[PSUM_W-1:0];
      case (sat_kind(sum[PSUM_W], sum[PSUM_W-1]))
         SAT_MAX: y = {1'b0, {(PSUM_W-1){1'b1}}};
         SAT_MIN: y = {1'b1, {(PSUM_W-1){1'b0}}};
         default: y = sum[PSUM_W-1:0];
      endcase
   end

endmodule

// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulator: group 0 beats are parked in the psum SRAM, group 1 beats
// are added to the parked sums, saturated and streamed out with plane/layer pulses.
module psum_acc_ctrl
   import psum_acc_pkg::*;
#(
   parameter int NLANE    = 32,
   parameter int PSUM_W   = 24,
   parameter int MAP_SIZE = 3136,
   parameter int NOCH     = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [31:0]             in_info,
   input  logic [NLANE*PSUM_W-1:0] in_data,
   output logic                    buf_wen,
   output logic [BUF_AW-1:0]       buf_waddr,
   output logic [NLANE*PSUM_W-1:0] buf_wdata,
   output logic                    buf_ren,
   output logic [BUF_AW-1:0]       buf_raddr,
   input  logic [NLANE*PSUM_W-1:0] buf_rdata,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [NLANE*PSUM_W-1:0] out_data,
   output logic [BUF_AW-1:0]       out_addr,
   output logic                    plane_done,
   output logic                    layer_done,
   output logic                    seq_err
);

   localparam int DW = NLANE * PSUM_W;
   localparam logic [INFO_OFF_W-1:0] LAST_OFF   = INFO_OFF_W'(MAP_SIZE - 1);
   localparam logic [6:0]            LAST_PLANE = 7'(NOCH - 1);

   logic                  advance;
   logic                  accept;
   logic                  in_grp;
   logic [BUF_AW-1:0]     in_addr;
   logic                  unused_info;

   logic                  s1_vld;
   logic                  s1_grp;
   logic [BUF_AW-1:0]     s1_addr;
   logic [DW-1:0]         s1_data;
   logic [DW-1:0]         sum_data;
   logic                  s2_go;

   logic [INFO_OFF_W-1:0] exp_off;
   logic                  exp_grp;
   logic [6:0]            plane_cnt;
   logic                  plane_last;

   // The whole pipe moves together; only a held output word stops it.
   assign advance = ~(out_vld & ~out_rdy);
   assign in_rdy  = advance;
   assign accept  = in_vld & advance;

   assign in_grp      = in_info[INFO_GRP_BIT];
   assign in_addr     = {in_info[INFO_HALF_BIT], in_info[INFO_OFF_W-1:0]};
   assign unused_info = ^in_info[31:14];

   assign buf_wen   = accept & ~in_grp;
   assign buf_waddr = in_addr;
   assign buf_wdata = in_data;
   assign buf_ren   = accept & in_grp;
   assign buf_raddr = in_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_grp  <= 1'b0;
         s1_addr <= '0;
         s1_data <= '0;
      end else if (advance) begin
         s1_vld <= accept;
         if (accept) begin
            s1_grp  <= in_grp;
            s1_addr <= in_addr;
            s1_data <= in_data;
         end
      end
   end

   for (genvar l = 0; l < NLANE; l++) begin : g_lane
      psum_sat_add #(
         .PSUM_W (PSUM_W)
      ) u_sat (
         .a (s1_data[l*PSUM_W +: PSUM_W]),
         .b (buf_rdata[l*PSUM_W +: PSUM_W]),
         .y (sum_data[l*PSUM_W +: PSUM_W])
      );
   end

   assign s2_go = advance & s1_vld & s1_grp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_addr <= '0;
      end else if (s2_go) begin
         out_vld  <= 1'b1;
         out_data <= sum_data;
         out_addr <= s1_addr;
      end else if (out_rdy) begin
         out_vld <= 1'b0;
      end
   end

   // Order tracker: flags a beat that is off the expected raster but still processes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_off <= '0;
         exp_grp <= 1'b0;
         seq_err <= 1'b0;
      end else if (accept) begin
         if ((in_info[INFO_OFF_W-1:0] != exp_off) || (in_grp != exp_grp)) seq_err <= 1'b1;
         if (exp_off == LAST_OFF) begin
            exp_off <= '0;
            exp_grp <= ~exp_grp;
         end else begin
            exp_off <= exp_off + INFO_OFF_W'(1);
         end
      end
   end

   assign plane_last = out_vld & out_rdy & (out_addr[INFO_OFF_W-1:0] == LAST_OFF);
   assign plane_done = plane_last;
   assign layer_done = plane_last & (plane_cnt == LAST_PLANE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plane_cnt <= '0;
      end else if (plane_last) begin
         plane_cnt <= (plane_cnt == LAST_PLANE) ? '0 : plane_cnt + 7'd1;
      end
   end

endmodule
